// File: rtl/mips_stream_pkg.sv
// Shared constants and types for the stream demux/mux family.
package mips_stream_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NUM_CH    = 4;

  typedef logic [1:0] sel_t;
endpackage

// File: rtl/stream_fifo.sv
// Single-channel FIFO with occupancy count; head reads as zero while empty.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Full refuses a push even when a pop happens on the same edge.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head is masked while the channel is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/demux4_32_stream.sv
// 1-to-4 stream demultiplexer: each accepted word goes to the FIFO of channel in_sel.
module demux4_32_stream
  import mips_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  sel_t                    in_sel,
  input  logic [WIDTH-1:0]        in_data,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic                    busy
);
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  assign in_ready = ~full[in_sel];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign push[k]      = in_valid & in_ready & (in_sel == sel_t'(k));
    assign pop[k]       = out_valid[k] & out_ready[k];
    assign out_valid[k] = ~empty[k];

    stream_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .data  (in_data),
      .full  (full[k]),
      .empty (empty[k]),
      .head  (out_data[k*WIDTH +: WIDTH])
    );
  end

  assign busy = |out_valid;
endmodule

// File: doc/demux4_32_stream.md
DEMUX4_32_STREAM -- requirements
Module: demux4_32_stream

Interface
REQ-001 Parameter WIDTH, default 32, data width of each word.
REQ-002 Parameter DEPTH, default 2, per-channel buffer entries; power of two, at least 2.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  upstream word offered.
REQ-006 in_ready  out  1  block accepts offered word this cycle.
REQ-007 in_sel  in  2  destination channel 0..3.
REQ-008 in_data  in  WIDTH  offered word.
REQ-009 out_valid  out  4  bit k: channel k holds a word.
REQ-010 out_ready  in  4  bit k: channel k consumer takes word.
REQ-011 out_data  out  4xWIDTH  packed; slice k is channel k head word.
REQ-012 busy  out  1  any channel non-empty.

Function
REQ-013 The block shall be the inverse of mux4_32: each accepted word shall be routed to channel in_sel only, with no copy to any other channel.
REQ-014 Each channel shall own an independent FIFO of DEPTH entries with its own occupancy count 0..DEPTH.
REQ-015 in_ready shall be combinational: high iff channel in_sel count < DEPTH; it shall not depend on in_valid or on out_ready.
REQ-016 Accept shall occur iff in_valid and in_ready are both high at a rising edge.
REQ-017 Channel k shall pop iff out_valid[k] and out_ready[k] are both high at a rising edge.
REQ-018 out_valid[k] shall be high iff count[k] > 0; out_data slice k shall be the oldest word in channel k, and all-zero while count[k] = 0.
REQ-019 Latency: a word accepted at edge N shall appear on its channel output after edge N when that channel was empty; otherwise it appears behind older words in order.
REQ-020 Per-channel order shall be FIFO; order across different channels is unconstrained.
REQ-021 Push and pop on the same channel at the same edge shall leave count unchanged and advance both pointers.
REQ-022 Full channel: in_ready shall be low for that channel even if it pops in the same cycle; no overwrite and no drop shall ever occur.
REQ-023 A full channel shall not stall words selected for other channels.
REQ-024 Read and write pointers shall wrap modulo DEPTH.
REQ-025 out_ready[k] asserted while channel k is empty shall have no effect.
REQ-026 in_sel and in_data shall be ignored while in_valid is low.
REQ-027 busy shall equal OR of out_valid.

Reset
REQ-028 While rst = 0 at a rising edge, all counts and pointers shall clear; out_valid = 0, out_data = 0, busy = 0, and in_ready = 1 on the cycle after.
REQ-029 Reset asserted mid-operation shall discard all buffered words, with no output of stale data afterwards; in_valid during reset shall not be accepted.

Structure
REQ-030 Package mips_stream_pkg shall hold WIDTH default constant, the channel-count constant 4 and the typedef for the 2-bit channel select.
REQ-031 The per-channel buffer shall be a sub-module stream_fifo (push/pop/full/empty/head), instantiated four times; the top shall contain only select decode and in_ready mux.

Verification
REQ-032 Reset: rst=0 two cycles, then rst=1 -> out_valid=4'b0000, busy=0, in_ready=1, out_data all zero.
REQ-033 Routing: send 0x11111111 sel=0 ... 0x44444444 sel=3, with out_ready=0 -> out_valid=4'b1111, each slice k holds its own word and no other.
REQ-034 Full/backpressure: send 0xA0, 0xA1, 0xA2 to sel=2 with out_ready=0 -> third offer sees in_ready=0; sel=1 word is still accepted in the next cycle.
REQ-035 Order/wrap: push 0xB0..0xB5 to channel 0 with out_ready[0]=1 continuously -> outputs B0..B5 in order, with no gaps after the first.
REQ-036 Simultaneous push/pop on a channel holding one word -> count stays 1, head advances to the new word.
REQ-037 Reset mid-stream with 2 words in channel 3 -> after reset out_valid[3]=0 and no old word ever appears.
